// File: rtl/sg_avg_filter.sv
// sg_avg_filter
//   Moving-average filter that sits directly after the SG signal generator.
//   Each accepted input sample produces one averaged output sample. The
//   average is taken over a window of N = 2**LOG2_N samples, and the window
//   is kept as a running sum plus a circular history buffer. There is one
//   register stage, and it sustains one sample per clock when the downstream
//   stage is not stalling.
//
//   Build option:
//     SG_AVG_ROUND_EN  defined     -> avg = (sum + N/2) >>> LOG2_N  (round half up)
//                      not defined -> avg = sum >>> LOG2_N          (floor)
//
//   Parameters:
//     DW      sample width (signed two's complement)
//     LOG2_N  log2 of the window length, 1..6
//
//   Ports:
//     clk      rising-edge clock
//     rst      asynchronous active-low reset
//     clear    synchronous flush of history, sum, fill state and output
//     in_req   upstream sample valid
//     in_rdy   block accepts in_dat this cycle (combinational)
//     in_dat   input sample
//     out_req  out_dat valid
//     out_rdy  downstream accepts out_dat
//     out_dat  averaged sample
//     primed   window holds N real samples since reset/clear
module sg_avg_filter #(
    parameter int DW     = 16,
    parameter int LOG2_N = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 in_req,
    output logic                 in_rdy,
    input  logic signed [DW-1:0] in_dat,
    output logic                 out_req,
    input  logic                 out_rdy,
    output logic signed [DW-1:0] out_dat,
    output logic                 primed
);

    localparam int N  = 1 << LOG2_N;
    localparam int SW = DW + LOG2_N;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                state;
    logic signed [DW-1:0]  hist [N];
    logic [LOG2_N-1:0]     wp;
    logic [LOG2_N-1:0]     fill_cnt;
    logic signed [SW-1:0]  sum;
    logic signed [SW-1:0]  sum_nxt;
    logic                  accept;

    // The sum of N samples of DW bits always fits in DW+LOG2_N bits. With
    // rounding enabled, the extra +N/2 still stays below 2**(SW-1).
    function automatic logic signed [DW-1:0] avg(input logic signed [SW-1:0] s);
        logic signed [SW-1:0] q;
`ifdef SG_AVG_ROUND_EN
        q = (s + SW'(N / 2)) >>> LOG2_N;
`else
        q = s >>> LOG2_N;
`endif
        return q[DW-1:0];
    endfunction

    // A held output must drain before a new sample can be taken. A new sample
    // can be taken in the same cycle that the held output drains.
    assign in_rdy  = !clear && (!out_req || out_rdy);
    assign accept  = in_req && in_rdy;

    // The new sample enters the window and the oldest sample, hist[wp],
    // leaves it.
    assign sum_nxt = sum + SW'(in_dat) - SW'(hist[wp]);

    // ---- stage 0: history, running sum, fill FSM and output register ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= FILL;
            wp       <= '0;
            fill_cnt <= '0;
            sum      <= '0;
            out_req  <= 1'b0;
            out_dat  <= '0;
            primed   <= 1'b0;
            for (int i = 0; i < N; i++) begin
                hist[i] <= '0;
            end
        end else if (clear) begin
            state    <= FILL;
            wp       <= '0;
            fill_cnt <= '0;
            sum      <= '0;
            out_req  <= 1'b0;
            out_dat  <= '0;
            primed   <= 1'b0;
            for (int i = 0; i < N; i++) begin
                hist[i] <= '0;
            end
        end else begin
            if (accept) begin
                hist[wp] <= in_dat;
                wp       <= wp + 1'b1;
                sum      <= sum_nxt;
                out_dat  <= avg(sum_nxt);
                out_req  <= 1'b1;
                // The fill counter saturates at N-1. The Nth accept moves
                // the FSM to RUN.
                if (state == FILL) begin
                    if (fill_cnt == '1) begin
                        state  <= RUN;
                        primed <= 1'b1;
                    end else begin
                        fill_cnt <= fill_cnt + 1'b1;
                    end
                end
            end else if (out_req && out_rdy) begin
                out_req <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sg_avg_filter.sv
// tb_sg_avg_filter
//   Directed bench for sg_avg_filter with the default parameters (DW=16, N=8).
//   It covers reset, ramp fill, negative values with pointer wrap,
//   backpressure, clear in the middle of a stream, and asynchronous reset.
module tb_sg_avg_filter;

    localparam int DW = 16;

    logic                 clk     = 1'b0;
    logic                 rst     = 1'b0;
    logic                 clear   = 1'b0;
    logic                 in_req  = 1'b0;
    logic                 in_rdy;
    logic signed [DW-1:0] in_dat  = '0;
    logic                 out_req;
    logic                 out_rdy = 1'b1;
    logic signed [DW-1:0] out_dat;
    logic                 primed;

    int nvec  = 0;
    int nerr  = 0;
    int n_in  = 0;
    int n_out = 0;
    int base_in;
    int base_out;

`ifdef SG_AVG_ROUND_EN
    int RAMP [10] = '{13, 25, 38, 50, 63, 75, 88, 100, 100, 100};
    int NEG  [9]  = '{0, 0, 0, 0, -1, -1, -1, -1, -1};
`else
    int RAMP [10] = '{12, 25, 37, 50, 62, 75, 87, 100, 100, 100};
    int NEG  [9]  = '{-1, -1, -1, -1, -1, -1, -1, -1, -1};
`endif

    sg_avg_filter #(.DW(DW), .LOG2_N(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .in_req  (in_req),
        .in_rdy  (in_rdy),
        .in_dat  (in_dat),
        .out_req (out_req),
        .out_rdy (out_rdy),
        .out_dat (out_dat),
        .primed  (primed)
    );

    always #5 clk = ~clk;

    // Handshake counters, used to check that no sample is lost or duplicated.
    always @(posedge clk) begin
        if (rst && in_req && in_rdy)
            n_in <= n_in + 1;
        if (rst && out_req && out_rdy && !clear)
            n_out <= n_out + 1;
    end

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present one sample, let it be accepted on the next edge, then check the
    // output register.
    task automatic push(input int d, input int exp, input string tag);
        in_req = 1'b1;
        in_dat = 16'(d);
        @(posedge clk);
        #1;
        in_req = 1'b0;
        check({tag, "_req"}, 32'(out_req), 1);
        check({tag, "_dat"}, 32'(out_dat), exp);
    endtask

    initial begin
        // Reset held low while the inputs toggle randomly.
        rst = 1'b0;
        repeat (4) begin
            in_req  = 1'($urandom_range(0, 1));
            in_dat  = 16'($urandom);
            out_rdy = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            check("rst_out_req", 32'(out_req), 0);
            check("rst_out_dat", 32'(out_dat), 0);
            check("rst_in_rdy",  32'(in_rdy),  1);
            check("rst_primed",  32'(primed),  0);
        end
        @(negedge clk);
        in_req  = 1'b0;
        out_rdy = 1'b1;
        rst     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_out_req", 32'(out_req), 0);
        check("idle_out_dat", 32'(out_dat), 0);
        check("idle_in_rdy",  32'(in_rdy),  1);
        check("idle_primed",  32'(primed),  0);

        // Ramp: ten samples of 100.
        for (int i = 0; i < 10; i++) begin
            push(100, RAMP[i], $sformatf("ramp%0d", i));
            if (i == 6) check("ramp_primed_lo", 32'(primed), 0);
            if (i == 7) check("ramp_primed_hi", 32'(primed), 1);
        end

        // Clear while an output is pending and in_req is high.
        clear  = 1'b1;
        in_req = 1'b1;
        in_dat = 16'sd100;
        #1;
        check("clr_in_rdy", 32'(in_rdy), 0);
        @(posedge clk);
        #1;
        clear  = 1'b0;
        in_req = 1'b0;
        check("clr_out_req", 32'(out_req), 0);
        check("clr_primed",  32'(primed),  0);
        push(100, RAMP[0], "clr_next");

        // Negative values, then wrap: slot 0 is overwritten by the 9th sample.
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        for (int i = 0; i < 8; i++) begin
            push(-1, NEG[i], $sformatf("neg%0d", i));
        end
        check("neg_primed", 32'(primed), 1);
        push(0, NEG[8], "neg_wrap");

        // Backpressure: out_rdy is low for 5 cycles partway through the stream.
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear    = 1'b0;
        base_in  = n_in;
        base_out = n_out;
        for (int i = 0; i < 3; i++) begin
            push(100, RAMP[i], $sformatf("bp%0d", i));
        end
        out_rdy = 1'b0;
        in_req  = 1'b1;
        in_dat  = 16'sd100;
        #1;
        check("bp_in_rdy_first", 32'(in_rdy), 0);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp_hold%0d_req", c), 32'(out_req), 1);
            check($sformatf("bp_hold%0d_dat", c), 32'(out_dat), RAMP[2]);
            check($sformatf("bp_hold%0d_rdy", c), 32'(in_rdy),  0);
        end
        out_rdy = 1'b1;
        @(posedge clk);
        #1;
        in_req = 1'b0;
        check("bp_release_dat", 32'(out_dat), RAMP[3]);
        for (int i = 4; i < 8; i++) begin
            push(100, RAMP[i], $sformatf("bp%0d", i));
        end
        @(posedge clk);
        #1;
        check("bp_drained",  32'(out_req), 0);
        check("bp_in_count",  n_in - base_in, 8);
        check("bp_out_count", n_out - base_out, 8);

        // Asynchronous reset between clock edges while an output is pending.
        push(100, 100, "ar_pre");
        #2;
        rst = 1'b0;
        #1;
        check("ar_out_req", 32'(out_req), 0);
        check("ar_out_dat", 32'(out_dat), 0);
        check("ar_primed",  32'(primed),  0);
        @(negedge clk);
        rst = 1'b1;
        push(800, 100, "ar_post");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
